// File: rtl/lk_warp_interp_if.sv
// ---------------------------------------------------------------------------
// lk_warp_interp_if
// Bus bundle for the bilinear warp reader.
//   Window read side : rd_en, rd_row, rd_col (reader -> window buffer)
//                      p00, p01, p10, p11   (window buffer -> reader, one
//                      cycle after rd_en)
//   Pixel stream side: out_valid, out_pix, out_last (reader -> It stage)
// master = warp reader, slave = window buffer / consumer.
// ---------------------------------------------------------------------------
interface lk_warp_interp_if #(
   parameter int PIX_W    = 8,
   parameter int OUT_FRAC = 4,
   parameter int AW       = 4
);
   logic                      rd_en;
   logic [AW-1:0]             rd_row;
   logic [AW-1:0]             rd_col;
   logic [PIX_W-1:0]          p00;
   logic [PIX_W-1:0]          p01;
   logic [PIX_W-1:0]          p10;
   logic [PIX_W-1:0]          p11;
   logic                      out_valid;
   logic [PIX_W+OUT_FRAC-1:0] out_pix;
   logic                      out_last;

   modport master (
      output rd_en, rd_row, rd_col, out_valid, out_pix, out_last,
      input  p00, p01, p10, p11
   );

   modport slave (
      input  rd_en, rd_row, rd_col, out_valid, out_pix, out_last,
      output p00, p01, p10, p11
   );
endinterface

// File: rtl/lk_warp_interp.sv
// ---------------------------------------------------------------------------
// lk_warp_interp
// Bilinear warp reader for the image2 side of the LK iteration loop. On
// start it latches the accumulated displacement, walks the PATCH x PATCH
// patch row-major issuing one 2x2 window read per cycle, and streams the
// bilinearly interpolated pixels (Q(PIX_W).(OUT_FRAC)) to the consumer.
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   start               : begin a run (only honoured when idle)
//   sumd{r,c}_int       : signed integer displacement per axis
//   sign_{r,c}          : sign of the full displacement sum
//   frac_{r,c}          : magnitude fraction, Q0.FRAC_W
//   busy, done          : run in progress / one-cycle end-of-run pulse
//   win_bus             : window read port and output pixel stream
// ---------------------------------------------------------------------------
module lk_warp_interp #(
   parameter int PIX_W    = 8,
   parameter int INT_W    = 6,
   parameter int FRAC_W   = 10,
   parameter int OUT_FRAC = 4,
   parameter int PATCH    = 5,
   parameter int WIN      = 16,
   parameter int ORG      = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic signed [INT_W-1:0]  sumdr_int,
   input  logic signed [INT_W-1:0]  sumdc_int,
   input  logic                     sign_r,
   input  logic                     sign_c,
   input  logic [FRAC_W-1:0]        frac_r,
   input  logic [FRAC_W-1:0]        frac_c,
   output logic                     busy,
   output logic                     done,
   lk_warp_interp_if.master         win_bus
);

   localparam int AW     = $clog2(WIN);
   localparam int CW     = (PATCH > 1) ? $clog2(PATCH) : 1;
   // Address arithmetic width: room for ORG + index + (int-1) with no wrap.
   localparam int SW     = INT_W + $clog2(ORG + PATCH + WIN) + 2;
   localparam int FW     = FRAC_W + 1;              // weights span 0..2^FRAC_W
   localparam int TW     = PIX_W + FW;              // horizontal result
   localparam int VW     = PIX_W + 2*FRAC_W + 1;    // vertical result
   localparam int OW     = PIX_W + OUT_FRAC;
   localparam int SH     = 2*FRAC_W - OUT_FRAC;
   localparam int STAGES = 2;

   localparam logic [FW-1:0]        ONE = {1'b1, {FRAC_W{1'b0}}};
   localparam logic [VW-1:0]        RND = VW'(1) << (SH-1);
   localparam logic signed [SW-1:0] HI  = SW'(WIN-2);
   localparam logic [CW-1:0]        LST = CW'(PATCH-1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

   typedef struct packed {
      logic signed [SW-1:0] base;
      logic [FW-1:0]        f;
   } axis_t;

   // A negative sum with a nonzero fraction sits below its integer part:
   // step the base down one and use the complementary weight.
   function automatic axis_t resolve(input logic signed [INT_W-1:0] di,
                                     input logic                    s,
                                     input logic [FRAC_W-1:0]       fr);
      axis_t a;
      a.base = {{(SW-INT_W){di[INT_W-1]}}, di};
      a.f    = {1'b0, fr};
      if (s && (fr != '0)) begin
         a.base = a.base - SW'(1);
         a.f    = ONE - {1'b0, fr};
      end
      return a;
   endfunction

   function automatic logic [AW-1:0] clamp(input logic signed [SW-1:0] p);
      logic signed [SW-1:0] c;
      c = p;
      if (p < 0)       c = '0;
      else if (p > HI) c = HI;
      return c[AW-1:0];
   endfunction

   state_t               state_q, state_d;
   axis_t                ax_r_q, ax_c_q;
   logic [CW-1:0]        i_q, j_q;
   logic                 rd_en, rd_last, fin;
   logic signed [SW-1:0] pos_r, pos_c;
   logic [STAGES:0]      vld_pipe, last_pipe;
   logic [TW-1:0]        top_q, bot_q, top_d, bot_d;
   logic [VW-1:0]        v_d;
   logic [OW-1:0]        pix_q, pix_d;
   logic                 done_q;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= fin;
      end
   end

   always_comb begin
      state_d = state_q;
      fin     = 1'b0;
      case (state_q)
         IDLE:  if (start) state_d = LOAD;
         LOAD:  state_d = RUN;
         RUN:   if (rd_last) state_d = DRAIN;
         DRAIN: if (vld_pipe[STAGES] && last_pipe[STAGES]) begin
                   state_d = IDLE;
                   fin     = 1'b1;
                end
         default: state_d = IDLE;
      endcase
   end

   assign rd_en   = (state_q == RUN);
   assign rd_last = rd_en && (i_q == LST) && (j_q == LST);
   assign busy    = (state_q != IDLE);
   assign done    = done_q;

   // ---------------- offset latch and patch counters ----------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         ax_r_q <= '0;
         ax_c_q <= '0;
         i_q    <= '0;
         j_q    <= '0;
      end else if (state_q == LOAD) begin
         ax_r_q <= resolve(sumdr_int, sign_r, frac_r);
         ax_c_q <= resolve(sumdc_int, sign_c, frac_c);
         i_q    <= '0;
         j_q    <= '0;
      end else if (rd_en) begin
         if (j_q == LST) begin
            j_q <= '0;
            i_q <= i_q + CW'(1);
         end else begin
            j_q <= j_q + CW'(1);
         end
      end
   end

   assign pos_r = SW'(ORG) + SW'(i_q) + ax_r_q.base;
   assign pos_c = SW'(ORG) + SW'(j_q) + ax_c_q.base;

   assign win_bus.rd_en  = rd_en;
   assign win_bus.rd_row = rd_en ? clamp(pos_r) : '0;
   assign win_bus.rd_col = rd_en ? clamp(pos_c) : '0;

   // ---------------- interpolation datapath ----------------
   // vld_pipe[0]: window data present, [1]: horizontal blend registered,
   // [2]: output pixel registered.
   always_comb begin
      top_d = TW'(win_bus.p00) * TW'(ONE - ax_c_q.f) + TW'(win_bus.p01) * TW'(ax_c_q.f);
      bot_d = TW'(win_bus.p10) * TW'(ONE - ax_c_q.f) + TW'(win_bus.p11) * TW'(ax_c_q.f);
      v_d   = VW'(top_q) * VW'(ONE - ax_r_q.f) + VW'(bot_q) * VW'(ax_r_q.f);
      // Round half up; the blend is convex so the result never overflows OW.
      pix_d = OW'((v_d + RND) >> SH);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_pipe  <= '0;
         last_pipe <= '0;
         top_q     <= '0;
         bot_q     <= '0;
         pix_q     <= '0;
      end else begin
         vld_pipe  <= {vld_pipe[STAGES-1:0], rd_en};
         last_pipe <= {last_pipe[STAGES-1:0], rd_last};
         if (vld_pipe[0]) begin
            top_q <= top_d;
            bot_q <= bot_d;
         end
         if (vld_pipe[1]) pix_q <= pix_d;
      end
   end

   assign win_bus.out_valid = vld_pipe[STAGES];
   assign win_bus.out_last  = last_pipe[STAGES];
   assign win_bus.out_pix   = pix_q;

endmodule

// File: tb/tb_lk_warp_interp.sv
// ---------------------------------------------------------------------------
// tb_lk_warp_interp
// Directed + randomized bench for lk_warp_interp. A window memory model
// answers the 2x2 reads; expected addresses and pixels come from a
// real-valued bilinear model of the warped position.
// ---------------------------------------------------------------------------
module tb_lk_warp_interp;
   localparam int PIX_W = 8, INT_W = 6, FRAC_W = 10, OUT_FRAC = 4;
   localparam int PATCH = 5, WIN = 16, ORG = 5, AW = 4;
   localparam int NPIX  = PATCH * PATCH;

   logic                    clk = 1'b0;
   logic                    reset = 1'b0;
   logic                    start = 1'b0;
   logic signed [INT_W-1:0] sumdr_int = '0, sumdc_int = '0;
   logic                    sign_r = 1'b0, sign_c = 1'b0;
   logic [FRAC_W-1:0]       frac_r = '0, frac_c = '0;
   logic                    busy, done;

   lk_warp_interp_if #(.PIX_W(PIX_W), .OUT_FRAC(OUT_FRAC), .AW(AW)) bus ();

   lk_warp_interp #(
      .PIX_W(PIX_W), .INT_W(INT_W), .FRAC_W(FRAC_W), .OUT_FRAC(OUT_FRAC),
      .PATCH(PATCH), .WIN(WIN), .ORG(ORG)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .sumdr_int(sumdr_int), .sumdc_int(sumdc_int),
      .sign_r(sign_r), .sign_c(sign_c),
      .frac_r(frac_r), .frac_c(frac_c),
      .busy(busy), .done(done),
      .win_bus(bus)
   );

   always #5 clk = ~clk;

   logic [PIX_W-1:0] win [WIN][WIN];

   // Window buffer: data for a read appears the cycle after rd_en.
   always @(posedge clk) begin
      if (bus.rd_en) begin
         bus.p00 <= win[bus.rd_row][bus.rd_col];
         bus.p01 <= win[bus.rd_row][int'(bus.rd_col) + 1];
         bus.p10 <= win[int'(bus.rd_row) + 1][bus.rd_col];
         bus.p11 <= win[int'(bus.rd_row) + 1][int'(bus.rd_col) + 1];
      end
   end

   int n_assert = 0;
   int n_fail   = 0;
   int exp_row [NPIX];
   int exp_col [NPIX];
   int exp_pix [NPIX];
   int first_pix, first_row, first_col;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Warped window coordinate of patch index ii along one axis: the top-left
   // tap is floor(position) clamped into the window, f the fractional weight.
   function automatic int axis(input int ii, input int dint, input bit s,
                               input int fr, output int f);
      real p;
      int  b;
      p = real'(ORG + ii + dint) + (s ? -real'(fr) : real'(fr)) / 1024.0;
      b = $rtoi($floor(p));
      f = $rtoi((p - real'(b)) * 1024.0);
      if (b < 0) b = 0;
      else if (b > WIN - 2) b = WIN - 2;
      return b;
   endfunction

   function automatic int model(input int r, input int c, input int fr, input int fc);
      real a, b, x;
      a = real'(fc) / 1024.0;
      b = real'(fr) / 1024.0;
      x = (1.0 - b) * ((1.0 - a) * real'(win[r][c])   + a * real'(win[r][c+1]))
        + b         * ((1.0 - a) * real'(win[r+1][c]) + a * real'(win[r+1][c+1]));
      return $rtoi($floor(x * 16.0 + 0.5));
   endfunction

   task automatic fill(input int mode);
      for (int r = 0; r < WIN; r++)
         for (int c = 0; c < WIN; c++)
            case (mode)
               0: win[r][c] = PIX_W'(r * 16 + c);
               1: win[r][c] = (c % 2 == 1) ? 8'd20 : 8'd10;
               2: win[r][c] = (c < ORG) ? 8'd0 : 8'd100;
               default: win[r][c] = PIX_W'($urandom_range(0, 255));
            endcase
   endtask

   // One full run, checked cycle by cycle from the start edge. With chain
   // set, start is raised in the done cycle and the next call continues.
   task automatic run(input int dr, input bit sr, input int fr,
                      input int dc, input bit sc, input int fc,
                      input bit mid, input bit chain, input string tag);
      int fwr, fwc, idx, last_k;
      sumdr_int = INT_W'(dr); sign_r = sr; frac_r = FRAC_W'(fr);
      sumdc_int = INT_W'(dc); sign_c = sc; frac_c = FRAC_W'(fc);
      for (int i = 0; i < PATCH; i++)
         for (int j = 0; j < PATCH; j++) begin
            idx = i * PATCH + j;
            exp_row[idx] = axis(i, dr, sr, fr, fwr);
            exp_col[idx] = axis(j, dc, sc, fc, fwc);
            exp_pix[idx] = model(exp_row[idx], exp_col[idx], fwr, fwc);
         end
      start = 1'b1;
      tick();                                  // cycle 1 (LOAD)
      start = 1'b0;
      chk({tag, " busy@1"}, 32'(busy), 32'd1);
      chk({tag, " rd_en@1"}, 32'(bus.rd_en), 32'd0);
      last_k = chain ? NPIX + 5 : NPIX + 6;
      for (int k = 2; k <= last_k; k++) begin
         if (mid && k == 10) start = 1'b1;
         if (mid && k == 11) start = 1'b0;
         tick();
         chk($sformatf("%s rd_en@%0d", tag, k), 32'(bus.rd_en), 32'(k >= 2 && k <= NPIX + 1));
         if (k >= 2 && k <= NPIX + 1) begin
            chk($sformatf("%s rd_row@%0d", tag, k), 32'(bus.rd_row), 32'(exp_row[k-2]));
            chk($sformatf("%s rd_col@%0d", tag, k), 32'(bus.rd_col), 32'(exp_col[k-2]));
            if (k == 2) begin
               first_row = int'(bus.rd_row);
               first_col = int'(bus.rd_col);
            end
         end
         chk($sformatf("%s out_valid@%0d", tag, k), 32'(bus.out_valid), 32'(k >= 5 && k <= NPIX + 4));
         if (k >= 5 && k <= NPIX + 4) begin
            chk($sformatf("%s out_pix@%0d", tag, k), 32'(bus.out_pix), 32'(exp_pix[k-5]));
            if (k == 5) first_pix = int'(bus.out_pix);
         end
         chk($sformatf("%s out_last@%0d", tag, k), 32'(bus.out_last), 32'(k == NPIX + 4));
         chk($sformatf("%s done@%0d", tag, k), 32'(done), 32'(k == NPIX + 5));
         chk($sformatf("%s busy@%0d", tag, k), 32'(busy), 32'(k < NPIX + 5));
      end
      if (chain) start = 1'b1;
   endtask

   task automatic rand_run(input bit chain, input string tag);
      bit sr, sc;
      int mr, mc;
      sr = 1'($urandom_range(0, 1));
      sc = 1'($urandom_range(0, 1));
      mr = sr ? $urandom_range(0, 32) : $urandom_range(0, 31);
      mc = sc ? $urandom_range(0, 32) : $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) begin   // bias toward in-window offsets
         mr = mr % 4;
         mc = mc % 4;
      end
      run(sr ? -mr : mr, sr, $urandom_range(0, 1023),
          sc ? -mc : mc, sc, $urandom_range(0, 1023), 1'b0, chain, tag);
   endtask

   initial begin
      int saw_done, saw_valid;

      // Reset state
      reset = 1'b0;
      tick(); tick();
      chk("rst rd_en", 32'(bus.rd_en), 32'd0);
      chk("rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst out_last", 32'(bus.out_last), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst rd_row", 32'(bus.rd_row), 32'd0);
      chk("rst rd_col", 32'(bus.rd_col), 32'd0);
      chk("rst out_pix", 32'(bus.out_pix), 32'd0);
      reset = 1'b1;
      tick();

      // Zero offset: pixels are the window itself, shifted to Q8.4
      fill(0);
      run(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, "zero");
      chk("zero first_pix", 32'(first_pix), 32'(((ORG * 16) + ORG) << 4));

      // Half-pixel column
      fill(1);
      run(0, 0, 0, 0, 0, 512, 1'b0, 1'b0, "half");
      chk("half first_pix", 32'(first_pix), 32'd240);

      // Negative fraction: base steps down, weight complements
      fill(2);
      run(0, 0, 0, 0, 1, 256, 1'b0, 1'b0, "negf");
      chk("negf first_col", 32'(first_col), 32'(ORG - 1));
      chk("negf first_pix", 32'(first_pix), 32'd1200);

      // Clamp at both ends
      fill(3);
      run(31, 0, 0, 0, 0, 300, 1'b0, 1'b0, "clamp_hi");
      chk("clamp_hi first_row", 32'(first_row), 32'd14);
      run(-32, 1, 0, -3, 1, 700, 1'b0, 1'b0, "clamp_lo");
      chk("clamp_lo first_row", 32'(first_row), 32'd0);

      // start while busy is ignored
      fill(3);
      run(1, 0, 100, -2, 1, 900, 1'b1, 1'b0, "midstart");

      // start in the done cycle chains directly into a new run
      rand_run(1'b1, "chain0");
      rand_run(1'b0, "chain1");

      // reset mid-run discards the run
      sumdr_int = '0; sign_r = 1'b0; frac_r = '0;
      sumdc_int = '0; sign_c = 1'b0; frac_c = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 2; k <= 11; k++) tick();
      reset = 1'b0;
      tick();
      chk("midrst rd_en", 32'(bus.rd_en), 32'd0);
      chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst out_last", 32'(bus.out_last), 32'd0);
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst done", 32'(done), 32'd0);
      chk("midrst rd_row", 32'(bus.rd_row), 32'd0);
      chk("midrst rd_col", 32'(bus.rd_col), 32'd0);
      chk("midrst out_pix", 32'(bus.out_pix), 32'd0);
      reset = 1'b1;
      saw_done = 0;
      saw_valid = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (done) saw_done++;
         if (bus.out_valid) saw_valid++;
      end
      chk("midrst no done", 32'(saw_done), 32'd0);
      chk("midrst no valid", 32'(saw_valid), 32'd0);
      run(2, 0, 513, 1, 0, 77, 1'b0, 1'b0, "postrst");

      // Randomized runs
      for (int n = 0; n < 6; n++) begin
         fill(3);
         rand_run(1'b0, $sformatf("rand%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
